speck_key_sched: RTL and testbench
==================================

Name: speck_key_sched

Overview:
Iterative Speck64/128 key-expansion stage that sits directly upstream of the Speck64 round datapath.
- Accepts a 128-bit master key on a start pulse.
- Generates the 27 round keys rk[0..26], one per handshake, on a valid/ready stream that the encryption core consumes in order.
- The key-schedule step reuses the round function, using the round index as the "key".

Parameters:
W, 32, word size in bits (Speck64); only 32 is supported.
ROUNDS, 27, number of round keys emitted.
IDX_W, 5, width of the round index; must satisfy 2**IDX_W >= ROUNDS.

Ports:
clk  input  1  single system clock; all logic rising-edge.
rst_n  input  1  synchronous, active-low reset.
start  input  1  one-cycle request to begin expansion; honoured only in IDLE.
key  input  4*W  master key {l2,l1,l0,k0}: k0=key[31:0], l0=key[63:32], l1=key[95:64], l2=key[127:96].
rk_valid  output  1  rk_data/rk_idx hold a valid round key.
rk_ready  input  1  consumer accepts the current round key.
rk_data  output  W  round key rk[rk_idx].
rk_idx  output  IDX_W  index of the presented round key, 0..ROUNDS-1.
busy  output  1  high while in RUN.
done  output  1  one-cycle pulse after rk[ROUNDS-1] is accepted.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE; rk_valid=0, rk_data=0, rk_idx=0, busy=0, done=0.
  - Internal k, l0, l1, l2 cleared.
  - Reset mid-RUN aborts immediately; no further keys are presented.
- States: IDLE, RUN.
- IDLE:
  - start=1 latches k<=key[31:0], l0<=key[63:32], l1<=key[95:64], l2<=key[127:96], rk_idx<=0.
  - Goes to RUN with rk_valid=1 on the next cycle, so rk[0]=k0 is presented 1 cycle after start.
  - key is sampled only in the start cycle.
- RUN:
  - rk_data = k register (registered, glitch-free); busy=1, rk_valid=1.
  - Handshake fires when rk_valid && rk_ready.
  - Without a handshake, rk_data and rk_idx hold stable. Arbitrary back-pressure is allowed, with no timeout.
- Handshake with rk_idx < ROUNDS-1 (one update per cycle):
  - new_l = (rotr(l0,8) + k) ^ zext(rk_idx), addition mod 2^32.
  - k <= rotl(k,3) ^ new_l.
  - l0 <= l1; l1 <= l2; l2 <= new_l.
  - rk_idx <= rk_idx + 1.
  - With rk_ready held high, one key is delivered per cycle: 27 keys in 27 consecutive cycles.
- Handshake with rk_idx == ROUNDS-1:
  - Next cycle: state=IDLE, rk_valid=0, busy=0, done=1 for exactly one cycle.
  - rk_idx returns to 0; rk_data holds its last value (don't-care).
- start while busy=1, including the final-handshake cycle, is ignored and not queued.
- start in the done=1 cycle (already IDLE) is accepted normally, so back-to-back runs have a 1-cycle bubble.
- rk_ready while rk_valid=0 has no effect.
- rk_idx never exceeds ROUNDS-1.

Decomposition:
- Shared package speck_pkg holds:
  - W=32, ROUNDS=27, IDX_W=5, ALPHA=8, BETA=3, KEY_W=128.
  - State enum {IDLE, RUN}.
  - Key-slice constants.
- Sub-module: instantiate the existing speck_round as the combinational step, with x_in=l0, y_in=k, k_in=zext(rk_idx).
  - x_out is new_l; y_out is next k.
  - This module adds only the registers, the FSM and the handshake.

Test Plan:
- Reset then start with key=0x1b1a1918_13121110_0b0a0908_03020100 and rk_ready=1 -> one cycle later rk_valid=1, rk_idx=0, rk_data=0x03020100; next cycle rk_idx=1, rk_data=0x131d0309; all 27 keys match the software model; done pulses 1 cycle after rk_idx=26 is accepted.
- Same key with rk_ready toggled pseudo-randomly (~40% duty) -> rk_data/rk_idx stable while stalled, same 27-key sequence, no key skipped or duplicated.
- start asserted during RUN at rk_idx=10 with a different key -> ignored; sequence continues unchanged; busy stays 1.
- rst_n=0 at rk_idx=15 -> next cycle rk_valid=0, busy=0, rk_idx=0, done=0; a following start yields rk[0] of the new key.
- start asserted in the done cycle with key=0 -> accepted; rk[0]=0x00000000, rk[1]=0x00000000 (all-zero key, index 0); subsequent keys match the model.
- rk_ready=1 held in IDLE with no start -> rk_valid stays 0; no state change, no done.

Source files
------------

// File: rtl/speck_pkg.sv
// Shared constants and helpers for the Speck64/128 key schedule and round function.
package speck_pkg;

    localparam int unsigned W      = 32;
    localparam int unsigned ROUNDS = 27;
    localparam int unsigned IDX_W  = 5;
    localparam int unsigned ALPHA  = 8;
    localparam int unsigned BETA   = 3;
    localparam int unsigned KEY_W  = 128;

    // Master key layout {l2, l1, l0, k0}
    localparam int unsigned K0_LSB = 0;
    localparam int unsigned L0_LSB = 32;
    localparam int unsigned L1_LSB = 64;
    localparam int unsigned L2_LSB = 96;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    function automatic logic [W-1:0] rotr(input logic [W-1:0] v, input int unsigned s);
        return (v >> s) | (v << (W - s));
    endfunction

    function automatic logic [W-1:0] rotl(input logic [W-1:0] v, input int unsigned s);
        return (v << s) | (v >> (W - s));
    endfunction

endpackage

// File: rtl/speck_key_sched_if.sv
// Round-key stream from the key schedule to the encryption core.
interface speck_key_sched_if;
    import speck_pkg::*;

    logic             rk_valid;
    logic             rk_ready;
    logic [W-1:0]     rk_data;
    logic [IDX_W-1:0] rk_idx;

    modport master (output rk_valid, output rk_data, output rk_idx, input rk_ready);
    modport slave  (input rk_valid, input rk_data, input rk_idx, output rk_ready);

endinterface

// File: rtl/speck_round.sv
// Combinational Speck64 round: x' = (rotr(x,8)+y)^k, y' = rotl(y,3)^x'.
module speck_round
    import speck_pkg::*;
(
    input  logic [W-1:0] x_in,
    input  logic [W-1:0] y_in,
    input  logic [W-1:0] k_in,
    output logic [W-1:0] x_out,
    output logic [W-1:0] y_out
);

    assign x_out = (rotr(x_in, ALPHA) + y_in) ^ k_in;
    assign y_out = rotl(y_in, BETA) ^ x_out;

endmodule

// File: rtl/speck_key_sched.sv
// Iterative Speck64/128 key expansion: emits rk[0..26] on a valid/ready stream.
module speck_key_sched
    import speck_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [KEY_W-1:0]     key,
    speck_key_sched_if.master    rk,
    output logic                 busy,
    output logic                 done
);

    logic [0:0]       state, state_n;
    logic [W-1:0]     k, k_n;
    logic [W-1:0]     l0, l0_n;
    logic [W-1:0]     l1, l1_n;
    logic [W-1:0]     l2, l2_n;
    logic [IDX_W-1:0] idx, idx_n;
    logic             valid, valid_n;
    logic             busy_n;
    logic             done_n;

    logic [W-1:0]     new_l;
    logic [W-1:0]     next_k;
    logic             fire;
    logic             last;

    // Schedule step reuses the round function with the round index as its key
    speck_round u_step (
        .x_in  (l0),
        .y_in  (k),
        .k_in  ({{(W - IDX_W){1'b0}}, idx}),
        .x_out (new_l),
        .y_out (next_k)
    );

    assign fire = valid && rk.rk_ready;
    assign last = (idx == IDX_W'(ROUNDS - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            k     <= '0;
            l0    <= '0;
            l1    <= '0;
            l2    <= '0;
            idx   <= '0;
            valid <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            k     <= k_n;
            l0    <= l0_n;
            l1    <= l1_n;
            l2    <= l2_n;
            idx   <= idx_n;
            valid <= valid_n;
            busy  <= busy_n;
            done  <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        k_n     = k;
        l0_n    = l0;
        l1_n    = l1;
        l2_n    = l2;
        idx_n   = idx;
        valid_n = valid;
        busy_n  = busy;
        done_n  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_n = ST_RUN;
                    k_n     = key[K0_LSB +: W];
                    l0_n    = key[L0_LSB +: W];
                    l1_n    = key[L1_LSB +: W];
                    l2_n    = key[L2_LSB +: W];
                    idx_n   = '0;
                    valid_n = 1'b1;
                    busy_n  = 1'b1;
                end
            end
            ST_RUN: begin
                if (fire) begin
                    if (last) begin
                        // rk_data keeps the last key; only the index rewinds
                        state_n = ST_IDLE;
                        idx_n   = '0;
                        valid_n = 1'b0;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                    end else begin
                        k_n   = next_k;
                        l0_n  = l1;
                        l1_n  = l2;
                        l2_n  = new_l;
                        idx_n = idx + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_n = ST_IDLE;
                valid_n = 1'b0;
                busy_n  = 1'b0;
            end
        endcase
    end

    assign rk.rk_valid = valid;
    assign rk.rk_data  = k;
    assign rk.rk_idx   = idx;

endmodule

// File: tb/tb_speck_key_sched.sv
// Directed bench for speck_key_sched against an independent key-schedule model.
module tb_speck_key_sched;
    import speck_pkg::*;

    localparam logic [127:0] KEY_A   = 128'h1b1a1918_13121110_0b0a0908_03020100;
    localparam logic [127:0] KEY_B   = 128'hdeadbeef_01234567_89abcdef_cafef00d;
    localparam logic [127:0] KEY_ALT = 128'hffffffff_eeeeeeee_dddddddd_cccccccc;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [127:0] key;
    logic         busy;
    logic         done;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_rk [ROUNDS];
    logic [31:0] rk1_seen;

    speck_key_sched_if rk ();

    speck_key_sched dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .key   (key),
        .rk    (rk.master),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference schedule written directly from the Speck64/128 definition
    task automatic gen_model(input logic [127:0] mk);
        logic [31:0] kk, a, b, c, nl;
        kk = mk[31:0];
        a  = mk[63:32];
        b  = mk[95:64];
        c  = mk[127:96];
        for (int i = 0; i < ROUNDS; i++) begin
            exp_rk[i] = kk;
            nl = ({a[7:0], a[31:8]} + kk) ^ 32'(i);
            kk = {kk[28:0], kk[31:29]} ^ nl;
            a  = b;
            b  = c;
            c  = nl;
        end
    endtask

    task automatic start_run(input logic [127:0] mk);
        key   = mk;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        key   = '0;
    endtask

    // Consume one full key sequence; called at the negedge after start
    task automatic collect(input int pct, input bit inj, input bit chain, input logic [127:0] nkey);
        int          n = 0;
        int          cyc = 0;
        bit          stalled = 1'b0;
        logic [31:0] pd = '0;
        logic [4:0]  pi = '0;
        while (n < ROUNDS && cyc < 3000) begin
            if (stalled) begin
                check_eq("stall_data", rk.rk_data, pd);
                check_eq("stall_idx", 32'(rk.rk_idx), 32'(pi));
            end
            stalled = 1'b0;
            if (inj) begin
                start = rk.rk_valid && (rk.rk_idx == 5'd10);
                key   = KEY_ALT;
            end
            rk.rk_ready = ($urandom_range(99) < pct);
            if (rk.rk_valid) begin
                check_eq("busy_run", 32'(busy), 32'd1);
                if (rk.rk_ready) begin
                    check_eq("rk_idx", 32'(rk.rk_idx), 32'(n));
                    check_eq("rk_data", rk.rk_data, exp_rk[n]);
                    if (n == 1) rk1_seen = rk.rk_data;
                    n++;
                end else begin
                    stalled = 1'b1;
                    pd      = rk.rk_data;
                    pi      = rk.rk_idx;
                end
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        if (n < ROUNDS) check_eq("timeout_keys", 32'(n), 32'(ROUNDS));
        if (pct >= 100) check_eq("back_to_back_cycles", 32'(cyc), 32'(ROUNDS));
        check_eq("done_pulse", 32'(done), 32'd1);
        check_eq("valid_after", 32'(rk.rk_valid), 32'd0);
        check_eq("busy_after", 32'(busy), 32'd0);
        check_eq("idx_after", 32'(rk.rk_idx), 32'd0);
        if (chain) begin
            key   = nkey;
            start = 1'b1;
        end
        @(negedge clk);
        start = 1'b0;
        check_eq("done_one_cycle", 32'(done), 32'd0);
    endtask

    initial begin
        int guard;
        rst_n       = 1'b0;
        start       = 1'b0;
        key         = '0;
        rk.rk_ready = 1'b0;
        rk1_seen    = '0;
        repeat (2) @(negedge clk);
        check_eq("rst_valid", 32'(rk.rk_valid), 32'd0);
        check_eq("rst_data", rk.rk_data, 32'd0);
        check_eq("rst_idx", 32'(rk.rk_idx), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;

        // Ready held high in IDLE without start
        rk.rk_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("idle_valid", 32'(rk.rk_valid), 32'd0);
            check_eq("idle_done", 32'(done), 32'd0);
            check_eq("idle_busy", 32'(busy), 32'd0);
        end

        // Full-rate run with hand-checked first keys
        gen_model(KEY_A);
        start_run(KEY_A);
        check_eq("first_valid", 32'(rk.rk_valid), 32'd1);
        check_eq("first_data_hand", rk.rk_data, 32'h03020100);
        collect(100, 1'b0, 1'b0, '0);
        check_eq("rk1_hand", rk1_seen, 32'h131d0309);

        // Random back-pressure
        start_run(KEY_A);
        collect(40, 1'b0, 1'b0, '0);

        // start during RUN at idx 10 is ignored
        start_run(KEY_A);
        collect(100, 1'b1, 1'b0, '0);

        // start in done cycle with an all-zero key
        start_run(KEY_A);
        collect(100, 1'b0, 1'b1, '0);
        gen_model('0);
        check_eq("zero_rk0", rk.rk_data, 32'h0);
        collect(70, 1'b0, 1'b0, '0);
        check_eq("zero_rk1_hand", rk1_seen, 32'h0);

        // Reset mid-run at idx 15, then restart with a new key
        gen_model(KEY_A);
        rk.rk_ready = 1'b1;
        start_run(KEY_A);
        guard = 0;
        while (!(rk.rk_valid && rk.rk_idx == 5'd15) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check_eq("reach_idx15", 32'(rk.rk_idx), 32'd15);
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("abort_valid", 32'(rk.rk_valid), 32'd0);
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_idx", 32'(rk.rk_idx), 32'd0);
        check_eq("abort_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("abort_stays_idle", 32'(rk.rk_valid), 32'd0);
        gen_model(KEY_B);
        start_run(KEY_B);
        check_eq("restart_rk0", rk.rk_data, 32'hcafef00d);
        collect(60, 1'b0, 1'b0, '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
